// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - RISC-V funct3 access-type codes used by the legality check and
//     the lane aligner.
//   - FSM state encoding for mem_access_unit.
package mem_access_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    RMW_RD,
    RMW_WAIT,
    RMW_WR
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane aligner.
//   functM  : funct3 access type of the held request
//   lane    : addr[1:0] of the held request
//   rword   : word read from the cache (load path)
//   mword   : word held in the RMW merge buffer (store path)
//   wdata   : core store data, low byte/half used for sb/sh
//   ld_data : extend(rword) - selected lane, sign/zero-extended
//   st_word : merge(mword)  - mword with the selected lane(s) replaced
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  functM,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] mword,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  function automatic logic [31:0] extend(input logic [2:0]  f,
                                         input logic [1:0]  a,
                                         input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LBU:  r = {24'h0, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LHU:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [2:0]  f,
                                        input logic [1:0]  a,
                                        input logic [31:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = m;
    case (f[1:0])
      2'b00:   r[{a, 3'b000} +: 8]     = d[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    ld_data = extend(functM, lane, rword);
    st_word = merge(functM, lane, mword, wdata);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit sitting in front of a word-only data cache.
// Loads: lane select + extension; miss waits MISS_LAT cycles in LD_WAIT.
// Stores: sw writes directly; sb/sh do read-modify-write through a merge
// buffer. Illegal/misaligned requests pulse mem_exc and touch no cache.
//   clka, rst(active-low, sync)       : clock / reset
//   req_valid, req_we, functM, addr,
//   wdata                             : core request (held while stall=1)
//   stall                             : combinational core stall
//   rdata, rdata_valid, mem_exc       : registered results / pulses
//   c_ena, c_wea, c_addr, c_dina      : cache request (word address)
//   c_douta, c_hit                    : cache response
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MISS_LAT = 1,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  functM,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        mem_exc,
  output logic        c_ena,
  output logic        c_wea,
  output logic [31:0] c_addr,
  output logic [31:0] c_dina,
  input  logic [31:0] c_douta,
  input  logic        c_hit
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MISS_LAT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [31:0]       mbuf;
  logic              ld_cap, buf_cap, valid_d, exc_d;
  logic              aligned, legal;
  logic [31:0]       ld_data, st_word;

  mem_lane_align u_align (
    .functM  (functM),
    .lane    (addr[1:0]),
    .rword   (c_douta),
    .mword   (mbuf),
    .wdata   (wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  assign c_addr = {2'b00, addr[31:2]};

  always_comb begin
    aligned = 1'b1;
    case (functM[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    if (req_we)
      legal = aligned && (functM inside {F3_LB, F3_LH, F3_LW});
    else
      legal = aligned && (functM inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ld_cap  = 1'b0;
    buf_cap = 1'b0;
    valid_d = 1'b0;
    exc_d   = 1'b0;
    c_ena   = 1'b0;
    c_wea   = 1'b0;
    c_dina  = '0;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            exc_d = 1'b1;
          end else if (!req_we) begin
            c_ena = 1'b1;
            if (c_hit) begin
              ld_cap  = 1'b1;
              valid_d = 1'b1;
            end else begin
              stall   = 1'b1;
              cnt_d   = '0;
              state_d = LD_WAIT;
            end
          end else if (functM == F3_LW) begin
            c_wea  = 1'b1;
            c_dina = wdata;
          end else begin
            stall   = 1'b1;
            state_d = RMW_RD;
          end
        end
      end
      LD_WAIT: begin
        c_ena = 1'b1;
        if (cnt == LAST_CNT) begin
          ld_cap  = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RMW_RD: begin
        c_ena = 1'b1;
        stall = 1'b1;
        if (c_hit) begin
          buf_cap = 1'b1;
          state_d = RMW_WR;
        end else begin
          cnt_d   = '0;
          state_d = RMW_WAIT;
        end
      end
      RMW_WAIT: begin
        c_ena = 1'b1;
        stall = 1'b1;
        if (cnt == LAST_CNT) begin
          buf_cap = 1'b1;
          state_d = RMW_WR;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RMW_WR: begin
        c_wea   = 1'b1;
        c_dina  = st_word;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset masks the cache strobes and stall combinationally so nothing
    // escapes during the reset cycle itself, not only after the edge.
    if (!rst) begin
      c_ena = 1'b0;
      c_wea = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge clka) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      mem_exc     <= 1'b0;
      mbuf        <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rdata_valid <= valid_d;
      mem_exc     <= exc_d;
      if (ld_cap)  rdata <= ld_data;
      if (buf_cap) mbuf  <= c_douta;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clka = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  functM;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, mem_exc;
  logic        c_ena, c_wea;
  logic [31:0] c_addr, c_dina, c_douta;
  logic        c_hit;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned both_cnt = 0;

  mem_access_unit #(.MISS_LAT(1), .CNT_W(2)) dut (
    .clka        (clka),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .functM      (functM),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mem_exc     (mem_exc),
    .c_ena       (c_ena),
    .c_wea       (c_wea),
    .c_addr      (c_addr),
    .c_dina      (c_dina),
    .c_douta     (c_douta),
    .c_hit       (c_hit)
  );

  always #5 clka = ~clka;

  always @(negedge clka) if (c_ena && c_wea) both_cnt++;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic req(input logic v, input logic we, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    functM    = f;
    addr      = a;
    wdata     = d;
  endtask

  task automatic cache(input logic hit, input logic [31:0] dout);
    c_hit   = hit;
    c_douta = dout;
  endtask

  task automatic strobes(input string tag, input logic ena, input logic wea, input logic stl);
    chk({tag, "_ena"},   {31'b0, c_ena}, {31'b0, ena});
    chk({tag, "_wea"},   {31'b0, c_wea}, {31'b0, wea});
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, stl});
  endtask

  initial begin
    // Reset with a legal hitting load presented: strobes must stay low.
    rst = 1'b0;
    req(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    cache(1'b1, 32'h1234_5678);
    #1;
    strobes("rst_comb", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rdata_valid}, 32'h0);
    chk("rst_exc", {31'b0, mem_exc}, 32'h0);
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    tick();

    // lb hit, byte lane 3 = 0x80 -> sign-extended
    req(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0);
    cache(1'b1, 32'h80FF_7F01);
    #1;
    chk("lb_caddr", c_addr, 32'h4);
    strobes("lb", 1'b1, 1'b0, 1'b0);
    tick();
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_rvalid", {31'b0, rdata_valid}, 32'h1);

    // lbu same word -> zero-extended
    req(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0);
    tick();
    chk("lbu_rdata", rdata, 32'h0000_0080);
    chk("lbu_rvalid", {31'b0, rdata_valid}, 32'h1);

    // idle: no access, rdata held, valid drops
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    strobes("idle", 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_rdata_hold", rdata, 32'h0000_0080);
    chk("idle_rvalid", {31'b0, rdata_valid}, 32'h0);

    // lhu miss at 0x22: one stall cycle, then sample c_douta in LD_WAIT
    req(1'b1, 1'b0, 3'b101, 32'h0000_0022, 32'h0);
    cache(1'b0, 32'h0);
    #1;
    chk("lhu_caddr", c_addr, 32'h8);
    strobes("lhu_miss", 1'b1, 1'b0, 1'b1);
    tick();
    chk("lhu_wait_rvalid", {31'b0, rdata_valid}, 32'h0);
    cache(1'b0, 32'hBEEF_1234);
    #1;
    strobes("lhu_wait", 1'b1, 1'b0, 1'b0);
    tick();
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    chk("lhu_rvalid", {31'b0, rdata_valid}, 32'h1);

    // lh hit, lower half 0x8001 -> sign-extended
    req(1'b1, 1'b0, 3'b001, 32'h0000_0020, 32'h0);
    cache(1'b1, 32'h1234_8001);
    tick();
    chk("lh_rdata", rdata, 32'hFFFF_8001);

    // lw hit
    req(1'b1, 1'b0, 3'b010, 32'h0000_0024, 32'h0);
    cache(1'b1, 32'hCAFE_BABE);
    tick();
    chk("lw_rdata", rdata, 32'hCAFE_BABE);

    // sb hit at 0x41: IDLE (stall, no access) -> RMW_RD -> RMW_WR
    req(1'b1, 1'b1, 3'b000, 32'h0000_0041, 32'hDEAD_BEAB);
    cache(1'b0, 32'h0);
    #1;
    strobes("sb_idle", 1'b0, 1'b0, 1'b1);
    tick();
    cache(1'b1, 32'h1122_3344);
    #1;
    strobes("sb_rd", 1'b1, 1'b0, 1'b1);
    tick();
    cache(1'b0, 32'h5A5A_5A5A);
    #1;
    strobes("sb_wr", 1'b0, 1'b1, 1'b0);
    chk("sb_dina", c_dina, 32'h1122_AB44);
    chk("sb_caddr", c_addr, 32'h10);
    tick();
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    strobes("sb_done", 1'b0, 1'b0, 1'b0);

    // sh miss at 0x42: RMW_RD miss -> RMW_WAIT -> RMW_WR, upper half replaced
    req(1'b1, 1'b1, 3'b001, 32'h0000_0042, 32'hFFFF_5566);
    tick();
    cache(1'b0, 32'h0);
    #1;
    strobes("sh_rd", 1'b1, 1'b0, 1'b1);
    tick();
    cache(1'b0, 32'hA1B2_C3D4);
    #1;
    strobes("sh_wait", 1'b1, 1'b0, 1'b1);
    tick();
    cache(1'b0, 32'h0);
    #1;
    strobes("sh_wr", 1'b0, 1'b1, 1'b0);
    chk("sh_dina", c_dina, 32'h5566_C3D4);
    tick();

    // illegal / misaligned requests
    req(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    cache(1'b1, 32'h0F0F_0F0F);
    #1;
    strobes("lw_mis", 1'b0, 1'b0, 1'b0);
    tick();
    chk("lw_mis_exc", {31'b0, mem_exc}, 32'h1);
    chk("lw_mis_rvalid", {31'b0, rdata_valid}, 32'h0);
    chk("lw_mis_rdata", rdata, 32'hCAFE_BABE);
    req(1'b1, 1'b1, 3'b001, 32'h0000_0003, 32'h1234);
    #1;
    strobes("sh_mis", 1'b0, 1'b0, 1'b0);
    tick();
    chk("sh_mis_exc", {31'b0, mem_exc}, 32'h1);
    req(1'b1, 1'b1, 3'b100, 32'h0000_0008, 32'h1234);
    #1;
    strobes("st100", 1'b0, 1'b0, 1'b0);
    tick();
    chk("st100_exc", {31'b0, mem_exc}, 32'h1);
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    chk("exc_clear", {31'b0, mem_exc}, 32'h0);
    chk("exc_rdata", rdata, 32'hCAFE_BABE);

    // back-to-back sw then lw to 0x30
    req(1'b1, 1'b1, 3'b010, 32'h0000_0030, 32'h0BAD_F00D);
    cache(1'b1, 32'h0);
    #1;
    strobes("b2b_sw", 1'b0, 1'b1, 1'b0);
    chk("b2b_sw_dina", c_dina, 32'h0BAD_F00D);
    chk("b2b_sw_caddr", c_addr, 32'hC);
    tick();
    req(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0);
    cache(1'b1, 32'h0BAD_F00D);
    #1;
    strobes("b2b_lw", 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_rdata", rdata, 32'h0BAD_F00D);
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();

    // reset during RMW_WAIT: the pending write must never appear
    req(1'b1, 1'b1, 3'b000, 32'h0000_0050, 32'h0000_0077);
    cache(1'b0, 32'h0);
    tick();
    tick();
    #1;
    strobes("rmw_wait_pre", 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    cache(1'b0, 32'h9999_9999);
    #1;
    strobes("rmw_rst_comb", 1'b0, 1'b0, 1'b0);
    tick();
    chk("rmw_rst_rdata", rdata, 32'h0);
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    strobes("post_rst0", 1'b0, 1'b0, 1'b0);
    tick();
    strobes("post_rst1", 1'b0, 1'b0, 1'b0);
    tick();
    strobes("post_rst2", 1'b0, 1'b0, 1'b0);

    // next sw writes in one cycle
    req(1'b1, 1'b1, 3'b010, 32'h0000_0060, 32'h1357_9BDF);
    #1;
    strobes("post_rst_sw", 1'b0, 1'b1, 1'b0);
    chk("post_rst_sw_dina", c_dina, 32'h1357_9BDF);
    tick();
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();

    chk("ena_wea_exclusive", both_cnt, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit directly upstream of the data cache; converts core requests (lb/lbu/lh/lhu/lw/sb/sh/sw) into word-only cache accesses.
- Selects byte lanes and sign/zero-extends load data.
- Performs sub-word stores as read-modify-write, because the cache writes whole words only.
- Stalls the core on cache misses and on RMW sequences.

Parameters:
- MISS_LAT, 1, cycles to hold a missed cache read before sampling c_douta (BRAM read latency).
- CNT_W, 2, width of the miss-wait counter; must hold MISS_LAT.

Ports:
- clka  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clka edge).
- req_valid  in  1  core memory request this cycle.
- req_we  in  1  1 = store, 0 = load.
- functM  in  3  RISC-V funct3 access type.
- addr  in  32  byte address.
- wdata  in  32  store data; low bytes are used for sb/sh.
- stall  out  1  combinational; core must hold all req_* inputs stable while it is 1.
- rdata  out  32  extended load result, registered.
- rdata_valid  out  1  one-cycle pulse, the cycle after a load completes.
- mem_exc  out  1  one-cycle pulse, the cycle after a misaligned or illegal request.
- c_ena  out  1  cache read enable.
- c_wea  out  1  cache write enable.
- c_addr  out  32  word address = {2'b0, addr[31:2]}.
- c_dina  out  32  cache write word.
- c_douta  in  32  cache read word.
- c_hit  in  1  cache hit, same cycle as the request.

Behaviour:
- Reset: state=IDLE, wait counter=0, rdata=0, rdata_valid=0, mem_exc=0, merge buffer=0. While rst=0: c_ena=0, c_wea=0, stall=0.
- Reset mid-operation: abandons any RMW or miss wait; no cache write is issued afterwards.
- Legality:
  - Loads: functM in {000,001,010,100,101}. Stores: functM in {000,001,010}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Illegal or misaligned request: no cache access, stall=0, mem_exc=1 next cycle.
- States: IDLE, LD_WAIT, RMW_RD, RMW_WAIT, RMW_WR.
- IDLE with legal load:
  - Drive c_ena=1.
  - c_hit=1: register extend(c_douta), rdata_valid=1 next cycle, stall=0, stay in IDLE.
  - c_hit=0: stall=1, counter=0, go to LD_WAIT.
- LD_WAIT:
  - c_ena held at 1; stall=1; counter increments each cycle.
  - When counter==MISS_LAT-1: sample c_douta regardless of c_hit, register the extended result, stall=0, go to IDLE. rdata_valid pulses next cycle.
- IDLE with sw: c_wea=1 and c_dina=wdata for one cycle; stall=0; stay in IDLE.
- IDLE with sb/sh: stall=1, go to RMW_RD. No cache access in this cycle.
- RMW_RD:
  - Drive c_ena=1.
  - c_hit=1: latch c_douta into the merge buffer, go to RMW_WR.
  - c_hit=0: go to RMW_WAIT; it uses the same counter rule as LD_WAIT, then latches c_douta and goes to RMW_WR.
  - stall=1 throughout.
- RMW_WR:
  - c_wea=1, c_dina = buffer with the selected lane(s) replaced by wdata[7:0] / wdata[15:0].
  - stall=0, go to IDLE.
- Lane select: byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh: sign-extend from bit 7 / bit 15 of the lane.
  - lbu/lhu: zero-extend.
- c_ena and c_wea are never both 1 in the same cycle.
- c_addr is driven from the held addr in every state.
- req_valid=0 in IDLE: no cache access, stall=0.
- Any req_valid seen outside IDLE is part of the held request, not a new one.
- rdata holds its value between loads; only rdata_valid marks new data.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - The state encoding.
- One combinational sub-module, mem_lane_align, contains extend() (load extension) and merge() (store lane merge), so the bench can reuse it as a reference model.

Test Plan:
- Load hit, lb: addr=0x0000_0013, c_hit=1, c_douta=0x80FF_7F01 -> c_addr=0x4, stall=0, next cycle rdata=0xFFFF_FF80, rdata_valid=1. Same with lbu -> rdata=0x0000_0080.
- Load miss, lhu, MISS_LAT=1: addr=0x22, c_hit=0, then c_douta=0xBEEF_1234 in LD_WAIT -> stall=1 for exactly 1 cycle, then rdata=0x0000_BEEF.
- sb RMW on a hit: addr=0x41, wdata=0xAB, cache word 0x1122_3344 -> RMW_RD, then RMW_WR with c_wea=1, c_dina=0x1122_AB44, c_addr=0x10; stall high for 2 cycles total.
- Misaligned or illegal: lw addr=0x6, sh addr=0x3, store functM=100 -> c_ena=c_wea=0, stall=0, mem_exc pulses once each, rdata unchanged.
- Reset mid-RMW: drop rst to 0 during RMW_WAIT -> no c_wea pulse ever follows; all outputs 0; the next sw after rst returns to 1 writes in 1 cycle.
- Back-to-back: sw then lw to the same address with a hit -> c_wea in cycle 0, c_ena in cycle 1; c_ena and c_wea never both 1.
